// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for the 5-stage pipeline (F, D, X, M, W).
// It drives the enable and clear inputs of the PC, FD, DX and XM registers.
// It detects load-use hazards and taken control transfers resolved in X.
// It also sequences the multicycle mult/div unit: it issues a start pulse,
// freezes F/D/X while the unit runs, and releases the pipeline when the
// result is ready or the run times out.
//
// Parameters:
//   MD_TIMEOUT  maximum mult/div run cycles before a forced abort (>= 2)
//   CNT_W       run counter width; 2**CNT_W must exceed MD_TIMEOUT
//
// Ports:
//   clock, reset       rising-edge clock; synchronous active-high reset
//   fd_rs, fd_rt       source registers of the instruction in FD
//   fd_uses_rt         the FD instruction actually reads rt
//   dx_rd              destination register of the instruction in DX
//   dx_is_load         the DX instruction is lw
//   dx_is_md           the DX instruction is mul/div
//   dx_br_taken        a DX branch/jump resolved taken
//   md_ready           mult/div result valid (level; only used while running)
//   pc_en/fd_en/dx_en  register enables
//   fd_flush/dx_flush  load a nop into FD/DX on the next latch
//   xm_bubble          load a nop into XM on the next latch
//   pc_sel_br          PC takes the branch target
//   md_start           one-cycle start pulse to the mult/div unit
//   md_wb_valid        the mult/div result may be latched into XM
//   md_timeout         one-cycle pulse when a run is aborted
//   stall_cycles       count of cycles with pc_en low
//
// Optional feature: define STALL_COUNT_EN to build the stall-cycle counter.
// Without it, stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        fd_uses_rt,
  input  logic [4:0]  dx_rd,
  input  logic        dx_is_load,
  input  logic        dx_is_md,
  input  logic        dx_br_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_bubble,
  output logic        pc_sel_br,
  output logic        md_start,
  output logic        md_wb_valid,
  output logic        md_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // Register 0 is hard-wired, so a load into it can never create a hazard.
  assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs) || (fd_uses_rt && (dx_rd == fd_rt)));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through this block leaves a value unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    dx_en       = 1'b1;
    fd_flush    = 1'b0;
    dx_flush    = 1'b0;
    xm_bubble   = 1'b0;
    pc_sel_br   = 1'b0;
    md_start    = 1'b0;
    md_wb_valid = 1'b0;
    md_timeout  = 1'b0;

    // While reset is high the defaults above are exactly the reset values.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (dx_is_md) begin
            // Decode guarantees no taken branch alongside a mult/div.
            md_start  = 1'b1;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
            state_d   = MD_RUN;
            cnt_d     = '0;
          end else if (dx_br_taken) begin
            // The squashed instructions make any load-use match irrelevant.
            pc_sel_br = 1'b1;
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
          end else if (load_use) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_flush = 1'b1;
          end
        end

        MD_RUN: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
          if (md_ready) begin
            state_d = MD_DONE;
          end else if (cnt_q == CNT_LAST) begin
            md_timeout = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        MD_DONE: begin
          // The result goes into XM this cycle while DX reloads normally.
          md_wb_valid = 1'b1;
          state_d     = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_en) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  // Reset also masks the count so the output is zero during the reset cycle.
  assign stall_cycles = reset ? 32'd0 : stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
